instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of the control unit. Holds the PC and issues one request per
//  instruction to instruction memory. It captures the returned word and presents it with its PC
//  and PC+4 to decode. Decode and the control unit receive the opcode[6:2] and funct3 slices.
//  It accepts a redirect (branch/JAL/JALR target) from execute and discards a fetch already in flight.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0013  value of if_instr while not valid (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req        out  1   one-cycle fetch request strobe
//  imem_addr       out  32  fetch address, word aligned ([1:0]=0)
//  imem_rvalid     in   1   response valid, >=1 cycle after imem_req
//  imem_rdata      in   32  response instruction word
//  stall           in   1   decode cannot accept the presented instruction
//  redirect_valid  in   1   execute requests a PC change
//  redirect_pc     in   32  target PC
//  if_valid        out  1   if_instr/if_pc/if_pc_plus4 are meaningful
//  if_instr        out  32  captured instruction
//  if_pc           out  32  PC of if_instr
//  if_pc_plus4     out  32  if_pc+4 (link value for JAL/JALR)
//  if_opcode       out  5   if_instr[6:2] to control unit
//  if_funct3       out  3   if_instr[14:12] to control unit
//  if_illegal      out  1   if_valid & (if_instr[1:0]!=2'b11)
//  fetch_misalign  out  1   one-cycle pulse: redirect_pc[1:0]!=0
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - pc=RESET_PC; state=FETCH; discard=0.
//   - if_valid=0; if_instr=NOP_INSTR; if_pc=RESET_PC; fetch_misalign=0.
//   - imem_req is 0 while rst=1.
//  FSM: FETCH -> WAIT -> HOLD -> FETCH.
//   - FETCH: imem_req=1, imem_addr=pc (combinational from state/pc); next state is WAIT.
//   - WAIT: imem_req=0. On imem_rvalid with discard=0: if_instr<=imem_rdata, if_pc<=pc,
//     if_valid<=1, pc<=pc+4; next state is HOLD. On imem_rvalid with discard=1: drop the
//     word, discard<=0; next state is FETCH.
//   - HOLD: outputs held stable while stall=1. When stall=0, the instruction is consumed
//     that cycle: if_valid<=0, if_instr<=NOP_INSTR; next state is FETCH.
//  Redirect (redirect_valid=1) has priority over stall and over imem_rvalid in the same cycle:
//   - pc<={redirect_pc[31:2],2'b00}; fetch_misalign<=|redirect_pc[1:0].
//   - if_valid<=0, if_instr<=NOP_INSTR.
//   - In FETCH or HOLD: next state is FETCH.
//   - In WAIT without imem_rvalid: set discard=1 and stay in WAIT until the response arrives.
//   - In WAIT with imem_rvalid the same cycle: drop the word; next state is FETCH.
//   - Redirect in FETCH: the request issued that cycle is still outstanding, so go to WAIT
//     with discard=1.
//  Misc:
//   - imem_rvalid in FETCH or HOLD (no request outstanding) is ignored.
//   - pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0); if_pc_plus4 wraps identically.
//   - At most one request outstanding; latency from consume to next if_valid >= 3 cycles.
//   - if_opcode, if_funct3 and if_illegal are combinational from if_instr/if_valid.
//   - Reset mid-WAIT: a late imem_rvalid after reset lands in FETCH/WAIT of the new stream.
//     The memory model must not return stale data after rst. The bench checks that no if_valid
//     appears before a post-reset request.
// TESTING
//  1. rst, RESET_PC=0, 1-cycle memory, stall=0 -> imem_addr 0,4,8 in successive FETCHes; if_pc
//     matches; if_opcode=if_instr[6:2]; if_pc_plus4=if_pc+4.
//  2. stall=1 for 3 cycles in HOLD -> if_valid=1 and if_instr/if_pc constant; no imem_req until
//     the cycle after stall=0.
//  3. 3-cycle memory, redirect to 0x100 during WAIT for 0x8 -> word for 0x8 never appears with
//     if_valid=1; next imem_addr=0x100.
//  4. redirect_valid and imem_rvalid in the same cycle -> word dropped, FETCH at target next
//     cycle; redirect in HOLD with stall=1 -> if_valid=0 next cycle.
//  5. redirect_pc=0x102 -> imem_addr=0x100, fetch_misalign=1 for exactly one cycle; fetched word
//     with [1:0]=2'b00 -> if_illegal=1.
//  6. RESET_PC=32'hFFFF_FFFC -> if_pc_plus4=0, second imem_addr=0; rst asserted in WAIT ->
//     if_valid=0, imem_addr=RESET_PC next FETCH.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/fetch FSM issuing one imem request per instruction, with redirect and in-flight discard
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [4:0]  if_opcode,
  output logic [2:0]  if_funct3,
  output logic        if_illegal,
  output logic        fetch_misalign
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, if_instr_q, if_instr_d, if_pc_q, if_pc_d;
  logic        discard_q, discard_d, if_valid_q, if_valid_d, misalign_q, misalign_d;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      state_d    = (state_q == HOLD || (state_q == WAIT && imem_rvalid)) ? FETCH : WAIT;
      discard_d  = (state_q == FETCH) || (state_q == WAIT && !imem_rvalid);
    end else if (state_q == FETCH) begin
      state_d = WAIT;
    end else if (state_q == WAIT && imem_rvalid) begin
      state_d   = discard_q ? FETCH : HOLD;
      discard_d = 1'b0;
      if (!discard_q) begin
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd4;
      end
    end else if (state_q == HOLD && !stall) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      state_d    = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      misalign_q <= misalign_d;
    end
  end
  assign imem_req       = (state_q == FETCH) && !rst;
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_q + 32'd4;
  assign if_opcode      = if_instr_q[6:2];
  assign if_funct3      = if_instr_q[14:12];
  assign if_illegal     = if_valid_q && (if_instr_q[1:0] != 2'b11);
  assign fetch_misalign = misalign_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven and sequence checks of instr_fetch_unit
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] I0   = 32'h0050_0093;
  localparam logic [31:0] I1   = 32'h00a0_2113;
  localparam logic [31:0] I2   = 32'h00f0_0193;
  localparam logic [31:0] I3   = 32'h0140_0213;
  localparam logic [31:0] I4   = 32'h0190_4293;
  localparam logic [31:0] I5   = 32'h00c2_8293;
  localparam logic [31:0] JUNK = 32'hdead_beef;
  localparam logic [31:0] TOP  = 32'hFFFF_FFFC;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, rv, stall, rdv;
  logic [31:0] rd, rdp;
  logic        req, valid, illegal, mis;
  logic [31:0] addr, instr, pc, pc4;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic        rst1, rv1, stall1, rdv1;
  logic [31:0] rd1, rdp1;
  logic        req1, valid1, illegal1, mis1;
  logic [31:0] addr1, instr1, pc1, pc41;
  logic [4:0]  opc1;
  logic [2:0]  f31;
  instr_fetch_unit #(.RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_rvalid(rv), .imem_rdata(rd),
    .stall(stall), .redirect_valid(rdv), .redirect_pc(rdp), .if_valid(valid), .if_instr(instr),
    .if_pc(pc), .if_pc_plus4(pc4), .if_opcode(opc), .if_funct3(f3), .if_illegal(illegal),
    .fetch_misalign(mis)
  );
  instr_fetch_unit #(.RESET_PC(TOP)) u1 (
    .clk(clk), .rst(rst1), .imem_req(req1), .imem_addr(addr1), .imem_rvalid(rv1), .imem_rdata(rd1),
    .stall(stall1), .redirect_valid(rdv1), .redirect_pc(rdp1), .if_valid(valid1), .if_instr(instr1),
    .if_pc(pc1), .if_pc_plus4(pc41), .if_opcode(opc1), .if_funct3(f31), .if_illegal(illegal1),
    .fetch_misalign(mis1)
  );
  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        rdv;
    logic [31:0] rdp;
    logic        req;
    logic [31:0] addr;
    logic        vl;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        mis;
  } vec_t;
  vec_t tv[30];
  int n_vec = 0;
  int n_err = 0;
  function automatic vec_t mv(input logic r, input logic [31:0] d, input logic s, input logic v,
                              input logic [31:0] p, input logic q, input logic [31:0] a,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                              input logic em);
    vec_t t;
    t.rv = r; t.rd = d; t.st = s; t.rdv = v; t.rdp = p;
    t.req = q; t.addr = a; t.vl = ev; t.ins = ei; t.pc = ep; t.mis = em;
    return t;
  endfunction
  function automatic logic [139:0] exp_bus(input logic q, input logic [31:0] a, input logic v,
                                           input logic [31:0] i, input logic [31:0] p,
                                           input logic m);
    logic [31:0] p4;
    p4 = p + 32'd4;
    return {q, a, v, i, p, p4, i[6:2], i[14:12], v && (i[1:0] != 2'b11), m};
  endfunction
  task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  function automatic logic [139:0] bus0();
    return {req, addr, valid, instr, pc, pc4, opc, f3, illegal, mis};
  endfunction
  function automatic logic [139:0] bus1();
    return {req1, addr1, valid1, instr1, pc1, pc41, opc1, f31, illegal1, mis1};
  endfunction
  initial begin
    tv[0]  = mv(0, 0,    0, 0, 0,     1, 0,     0, NOP, 0,     0);
    tv[1]  = mv(1, I0,   0, 0, 0,     0, 0,     0, NOP, 0,     0);
    tv[2]  = mv(0, 0,    0, 0, 0,     0, 4,     1, I0,  0,     0);
    tv[3]  = mv(0, 0,    0, 0, 0,     1, 4,     0, NOP, 0,     0);
    tv[4]  = mv(1, I1,   0, 0, 0,     0, 4,     0, NOP, 0,     0);
    tv[5]  = mv(0, 0,    1, 0, 0,     0, 8,     1, I1,  4,     0);
    tv[6]  = mv(0, 0,    1, 0, 0,     0, 8,     1, I1,  4,     0);
    tv[7]  = mv(0, 0,    1, 0, 0,     0, 8,     1, I1,  4,     0);
    tv[8]  = mv(0, 0,    0, 0, 0,     0, 8,     1, I1,  4,     0);
    tv[9]  = mv(0, 0,    0, 0, 0,     1, 8,     0, NOP, 4,     0);
    tv[10] = mv(0, 0,    0, 1, 'h100, 0, 8,     0, NOP, 4,     0);
    tv[11] = mv(0, 0,    0, 0, 0,     0, 'h100, 0, NOP, 4,     0);
    tv[12] = mv(1, I2,   0, 0, 0,     0, 'h100, 0, NOP, 4,     0);
    tv[13] = mv(0, 0,    0, 0, 0,     1, 'h100, 0, NOP, 4,     0);
    tv[14] = mv(1, I3,   0, 1, 'h200, 0, 'h100, 0, NOP, 4,     0);
    tv[15] = mv(0, 0,    0, 0, 0,     1, 'h200, 0, NOP, 4,     0);
    tv[16] = mv(1, I4,   0, 0, 0,     0, 'h200, 0, NOP, 4,     0);
    tv[17] = mv(0, 0,    1, 1, 'h102, 0, 'h204, 1, I4,  'h200, 0);
    tv[18] = mv(0, 0,    0, 0, 0,     1, 'h100, 0, NOP, 'h200, 1);
    tv[19] = mv(1, 0,    0, 0, 0,     0, 'h100, 0, NOP, 'h200, 0);
    tv[20] = mv(0, 0,    1, 0, 0,     0, 'h104, 1, 0,   'h100, 0);
    tv[21] = mv(0, 0,    0, 0, 0,     0, 'h104, 1, 0,   'h100, 0);
    tv[22] = mv(1, JUNK, 0, 0, 0,     1, 'h104, 0, NOP, 'h100, 0);
    tv[23] = mv(0, 0,    0, 0, 0,     0, 'h104, 0, NOP, 'h100, 0);
    tv[24] = mv(1, I5,   0, 0, 0,     0, 'h104, 0, NOP, 'h100, 0);
    tv[25] = mv(1, JUNK, 1, 0, 0,     0, 'h108, 1, I5,  'h104, 0);
    tv[26] = mv(0, 0,    0, 0, 0,     0, 'h108, 1, I5,  'h104, 0);
    tv[27] = mv(0, 0,    0, 1, 'h300, 1, 'h108, 0, NOP, 'h104, 0);
    tv[28] = mv(1, JUNK, 0, 0, 0,     0, 'h300, 0, NOP, 'h104, 0);
    tv[29] = mv(0, 0,    0, 0, 0,     1, 'h300, 0, NOP, 'h104, 0);
    rst = 1; rv = 0; rd = 0; stall = 0; rdv = 0; rdp = 0;
    rst1 = 1; rv1 = 0; rd1 = 0; stall1 = 0; rdv1 = 0; rdp1 = 0;
    repeat (2) @(negedge clk);
    #1 chk("rst_req", {139'd0, req}, 140'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst = 0; rv = tv[i].rv; rd = tv[i].rd; stall = tv[i].st; rdv = tv[i].rdv; rdp = tv[i].rdp;
      #1 chk($sformatf("vec%0d", i), bus0(),
             exp_bus(tv[i].req, tv[i].addr, tv[i].vl, tv[i].ins, tv[i].pc, tv[i].mis));
    end
    @(negedge clk);
    rst = 1; rv = 0; stall = 0; rdv = 0;
    #1 chk("rst_in_wait_req", {139'd0, req}, 140'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("post_rst_fetch", bus0(), exp_bus(1, 0, 0, NOP, 0, 0));
    @(negedge clk);
    rv = 1; rd = I0;
    #1 chk("post_rst_wait", bus0(), exp_bus(0, 0, 0, NOP, 0, 0));
    @(negedge clk);
    rv = 0;
    #1 chk("post_rst_hold", bus0(), exp_bus(0, 4, 1, I0, 0, 0));
    @(negedge clk);
    #1 chk("wrap_rst_req", {139'd0, req1}, 140'd0);
    @(negedge clk);
    rst1 = 0;
    #1 chk("wrap_fetch0", bus1(), exp_bus(1, TOP, 0, NOP, TOP, 0));
    @(negedge clk);
    rv1 = 1; rd1 = I1;
    #1 chk("wrap_wait0", bus1(), exp_bus(0, TOP, 0, NOP, TOP, 0));
    @(negedge clk);
    rv1 = 0;
    #1 chk("wrap_hold", bus1(), exp_bus(0, 0, 1, I1, TOP, 0));
    chk("wrap_plus4", {108'd0, pc41}, 140'd0);
    @(negedge clk);
    #1 chk("wrap_fetch1", bus1(), exp_bus(1, 0, 0, NOP, TOP, 0));
    @(negedge clk);
    rst1 = 1;
    #1 chk("wrap_rst_wait_req", {139'd0, req1}, 140'd0);
    @(negedge clk);
    rst1 = 0;
    #1 chk("wrap_refetch", bus1(), exp_bus(1, TOP, 0, NOP, TOP, 0));
    @(negedge clk);
    #1 chk("wrap_rewait", bus1(), exp_bus(0, TOP, 0, NOP, TOP, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
